// File: rtl/reservation_station.sv
// Issue queue between dispatch and the ALU.
// Lowest-index allocation and select, with CDB wakeup and dispatch bypass.
module reservation_station #(
  parameter int RS_DEPTH = 16,
  parameter int XLEN     = 32,
  parameter int ROB_W    = 4,
  parameter int OP_W     = 6,
  parameter int CDB_NUM  = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [OP_W-1:0]              disp_op,
  input  logic [XLEN-1:0]              disp_imm,
  input  logic [XLEN-1:0]              disp_pc,
  input  logic [ROB_W-1:0]             disp_rob,
  input  logic                         disp_rs1_rdy,
  input  logic [XLEN-1:0]              disp_rs1_val,
  input  logic [ROB_W-1:0]             disp_rs1_tag,
  input  logic                         disp_rs2_rdy,
  input  logic [XLEN-1:0]              disp_rs2_val,
  input  logic [ROB_W-1:0]             disp_rs2_tag,
  input  logic [CDB_NUM-1:0]           cdb_valid,
  input  logic [CDB_NUM*ROB_W-1:0]     cdb_tag,
  input  logic [CDB_NUM*XLEN-1:0]      cdb_val,
  input  logic                         alu_ready,
  output logic                         alu_valid,
  output logic [OP_W-1:0]              alu_op,
  output logic [XLEN-1:0]              alu_v1,
  output logic [XLEN-1:0]              alu_v2,
  output logic [XLEN-1:0]              alu_imm,
  output logic [XLEN-1:0]              alu_pc,
  output logic [ROB_W-1:0]             alu_rob,
  output logic [$clog2(RS_DEPTH+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH+1);

  typedef struct packed {
    logic             used;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0]  v1;
    logic [ROB_W-1:0] q1;
    logic             r1;
    logic [XLEN-1:0]  v2;
    logic [ROB_W-1:0] q2;
    logic             r2;
  } ent_t;

  ent_t r_ent [RS_DEPTH];
  ent_t w_nxt [RS_DEPTH];
  ent_t w_new;

  logic [RS_DEPTH-1:0] w_used;
  logic [RS_DEPTH-1:0] w_rdy;
  logic                w_free_found;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_cand_found;
  logic [IDX_W-1:0]    w_cand_idx;
  logic                w_fire;
  logic                w_issue;

  logic                r_alu_valid;
  logic [OP_W-1:0]     r_alu_op;
  logic [XLEN-1:0]     r_alu_v1;
  logic [XLEN-1:0]     r_alu_v2;
  logic [XLEN-1:0]     r_alu_imm;
  logic [XLEN-1:0]     r_alu_pc;
  logic [ROB_W-1:0]    r_alu_rob;
  logic [CNT_W-1:0]    r_occ;

  // Returns {ready, value}; lowest matching channel wins.
  function automatic logic [XLEN:0] snoop(
    input logic                     rdy,
    input logic [XLEN-1:0]          val,
    input logic [ROB_W-1:0]         tag,
    input logic [CDB_NUM-1:0]       cv,
    input logic [CDB_NUM*ROB_W-1:0] ct,
    input logic [CDB_NUM*XLEN-1:0]  cd
  );
    logic [XLEN:0] res;
    res = {rdy, val};
    if (!rdy) begin
      for (int k = CDB_NUM-1; k >= 0; k--) begin
        if (cv[k] && (ct[k*ROB_W +: ROB_W] == tag)) begin
          res = {1'b1, cd[k*XLEN +: XLEN]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_used[i] = r_ent[i].used;
      w_rdy[i]  = r_ent[i].used & r_ent[i].r1 & r_ent[i].r2;
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    for (int i = RS_DEPTH-1; i >= 0; i--) begin
      if (!w_used[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
      if (w_rdy[i]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_ready = w_free_found;
  assign w_fire     = disp_valid & w_free_found;
  assign w_issue    = w_cand_found & alu_ready;

  always_comb begin
    w_new      = '0;
    w_new.used = 1'b1;
    w_new.op   = disp_op;
    w_new.imm  = disp_imm;
    w_new.pc   = disp_pc;
    w_new.rob  = disp_rob;
    w_new.q1   = disp_rs1_tag;
    w_new.q2   = disp_rs2_tag;
    {w_new.r1, w_new.v1} = snoop(disp_rs1_rdy, disp_rs1_val,
                                 disp_rs1_tag, cdb_valid, cdb_tag, cdb_val);
    {w_new.r2, w_new.v2} = snoop(disp_rs2_rdy, disp_rs2_val,
                                 disp_rs2_tag, cdb_valid, cdb_tag, cdb_val);
  end

  // Flush wins over wakeup, issue and dispatch.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_nxt[i] = r_ent[i];
    end
    if (flush_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        w_nxt[i].used = 1'b0;
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        {w_nxt[i].r1, w_nxt[i].v1} = snoop(r_ent[i].r1, r_ent[i].v1,
                                           r_ent[i].q1, cdb_valid,
                                           cdb_tag, cdb_val);
        {w_nxt[i].r2, w_nxt[i].v2} = snoop(r_ent[i].r2, r_ent[i].v2,
                                           r_ent[i].q2, cdb_valid,
                                           cdb_tag, cdb_val);
      end
      if (w_issue) begin
        w_nxt[w_cand_idx].used = 1'b0;
      end
      if (w_fire) begin
        w_nxt[w_free_idx] = w_new;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (rdy_in) begin
      r_ent <= w_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_alu_valid <= 1'b0;
      r_alu_op    <= '0;
      r_alu_v1    <= '0;
      r_alu_v2    <= '0;
      r_alu_imm   <= '0;
      r_alu_pc    <= '0;
      r_alu_rob   <= '0;
      r_occ       <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_alu_valid <= 1'b0;
        r_occ       <= '0;
      end else begin
        r_alu_valid <= w_issue;
        if (w_issue) begin
          r_alu_op  <= r_ent[w_cand_idx].op;
          r_alu_v1  <= r_ent[w_cand_idx].v1;
          r_alu_v2  <= r_ent[w_cand_idx].v2;
          r_alu_imm <= r_ent[w_cand_idx].imm;
          r_alu_pc  <= r_ent[w_cand_idx].pc;
          r_alu_rob <= r_ent[w_cand_idx].rob;
        end
        unique case ({w_fire, w_issue})
          2'b10:   r_occ <= r_occ + CNT_W'(1);
          2'b01:   r_occ <= r_occ - CNT_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

  assign alu_valid = r_alu_valid;
  assign alu_op    = r_alu_op;
  assign alu_v1    = r_alu_v1;
  assign alu_v2    = r_alu_v2;
  assign alu_imm   = r_alu_imm;
  assign alu_pc    = r_alu_pc;
  assign alu_rob   = r_alu_rob;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station.
// Inputs change 1 time unit after a rising edge; outputs sampled there too.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic        disp_valid;
  logic        disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_imm;
  logic [31:0] disp_pc;
  logic [3:0]  disp_rob;
  logic        disp_rs1_rdy;
  logic [31:0] disp_rs1_val;
  logic [3:0]  disp_rs1_tag;
  logic        disp_rs2_rdy;
  logic [31:0] disp_rs2_val;
  logic [3:0]  disp_rs2_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_val;
  logic        alu_ready;
  logic        alu_valid;
  logic [5:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [31:0] alu_imm;
  logic [31:0] alu_pc;
  logic [3:0]  alu_rob;
  logic [4:0]  occupancy;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .flush_in(flush_in), .disp_valid(disp_valid),
    .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_val(disp_rs1_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs2_val(disp_rs2_val), .disp_rs2_tag(disp_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_op(alu_op),
    .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob(alu_rob), .occupancy(occupancy)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    flush_in   = 1'b0;
  endtask

  task automatic drive(input logic [5:0] op,
                       input logic r1, input logic [31:0] v1,
                       input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2,
                       input logic [3:0] t2, input logic [3:0] rob);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_rs1_rdy = r1;
    disp_rs1_val = v1;
    disp_rs1_tag = t1;
    disp_rs2_rdy = r2;
    disp_rs2_val = v2;
    disp_rs2_tag = t2;
    disp_rob     = rob;
    disp_imm     = 32'h1000 + 32'(rob);
    disp_pc      = 32'h8000 + 32'(rob) * 4;
  endtask

  task automatic cdb(input int ch, input logic [3:0] tag,
                     input logic [31:0] val);
    cdb_valid[ch]         = 1'b1;
    cdb_tag[ch*4 +: 4]    = tag;
    cdb_val[ch*32 +: 32]  = val;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; alu_ready = 1'b1;
    disp_op = '0; disp_imm = '0; disp_pc = '0; disp_rob = '0;
    disp_rs1_rdy = 0; disp_rs1_val = '0; disp_rs1_tag = '0;
    disp_rs2_rdy = 0; disp_rs2_val = '0; disp_rs2_tag = '0;
    cdb_tag = '0; cdb_val = '0;
    idle();
    #3;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", alu_valid); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", occupancy); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rst_dready got %0h exp 1", disp_ready); end
    checks++; if (alu_v1 !== 32'h0) begin errors++; $display("FAIL rst_v1 got %0h exp 0", alu_v1); end
    checks++; if (alu_rob !== 4'h0) begin errors++; $display("FAIL rst_rob got %0h exp 0", alu_rob); end
    #9 rst_in = 1'b1;
  endtask

  task automatic test_basic();
    drive(6'h01, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3);
    tick();
    idle();
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL basic_occ1 got %0d exp 1", occupancy); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0h exp 0", alu_valid); end
    tick();
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0h exp 1", alu_valid); end
    checks++; if (alu_v1 !== 32'd5) begin errors++; $display("FAIL basic_v1 got %0h exp 5", alu_v1); end
    checks++; if (alu_v2 !== 32'd7) begin errors++; $display("FAIL basic_v2 got %0h exp 7", alu_v2); end
    checks++; if (alu_rob !== 4'd3) begin errors++; $display("FAIL basic_rob got %0h exp 3", alu_rob); end
    checks++; if (alu_op !== 6'h01) begin errors++; $display("FAIL basic_op got %0h exp 1", alu_op); end
    checks++; if (alu_imm !== 32'h1003) begin errors++; $display("FAIL basic_imm got %0h exp 1003", alu_imm); end
    checks++; if (alu_pc !== 32'h800c) begin errors++; $display("FAIL basic_pc got %0h exp 800c", alu_pc); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL basic_occ0 got %0d exp 0", occupancy); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %0h exp 0", alu_valid); end
  endtask

  task automatic test_wakeup();
    drive(6'h02, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0, 4'd4);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_wait got %0h exp 0", alu_valid); end
    cdb(0, 4'd7, 32'h77);
    cdb(1, 4'd2, 32'h99);
    tick();
    idle();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL wake_nobypass got %0h exp 0", alu_valid); end
    tick();
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL wake_valid got %0h exp 1", alu_valid); end
    checks++; if (alu_v1 !== 32'h99) begin errors++; $display("FAIL wake_v1 got %0h exp 99", alu_v1); end
    checks++; if (alu_v2 !== 32'h1) begin errors++; $display("FAIL wake_v2 got %0h exp 1", alu_v2); end
    checks++; if (alu_rob !== 4'd4) begin errors++; $display("FAIL wake_rob got %0h exp 4", alu_rob); end
    tick();
  endtask

  task automatic test_cdb_priority();
    drive(6'h03, 0, 32'd0, 4'd6, 0, 32'd0, 4'd6, 4'd5);
    tick();
    idle();
    cdb(0, 4'd6, 32'h11);
    cdb(1, 4'd6, 32'h22);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %0h exp 1", alu_valid); end
    checks++; if (alu_v1 !== 32'h11) begin errors++; $display("FAIL prio_v1 got %0h exp 11", alu_v1); end
    checks++; if (alu_v2 !== 32'h11) begin errors++; $display("FAIL prio_v2 got %0h exp 11", alu_v2); end
    tick();
  endtask

  task automatic test_bypass();
    drive(6'h04, 1, 32'h10, 4'd0, 0, 32'd0, 4'd4, 4'd6);
    cdb(0, 4'd4, 32'hAB);
    tick();
    idle();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL byp_early got %0h exp 0", alu_valid); end
    tick();
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %0h exp 1", alu_valid); end
    checks++; if (alu_v2 !== 32'hAB) begin errors++; $display("FAIL byp_v2 got %0h exp ab", alu_v2); end
    checks++; if (alu_v1 !== 32'h10) begin errors++; $display("FAIL byp_v1 got %0h exp 10", alu_v1); end
    checks++; if (alu_rob !== 4'd6) begin errors++; $display("FAIL byp_rob got %0h exp 6", alu_rob); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(6'h05, 1, 32'hA, 4'd0, 1, 32'hB, 4'd0, 4'd1);
    tick();
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL b2b_occ1 got %0d exp 1", occupancy); end
    drive(6'h05, 1, 32'hC, 4'd0, 1, 32'hD, 4'd0, 4'd2);
    tick();
    idle();
    checks++; if (alu_rob !== 4'd1 || alu_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got rob %0h v %0h exp rob 1 v 1", alu_rob, alu_valid); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL b2b_occ_same got %0d exp 1", occupancy); end
    tick();
    checks++; if (alu_rob !== 4'd2 || alu_v1 !== 32'hC) begin errors++; $display("FAIL b2b_second got rob %0h v1 %0h exp rob 2 v1 c", alu_rob, alu_v1); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL b2b_occ0 got %0d exp 0", occupancy); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0h exp 0", alu_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      drive(6'h06, 0, 32'd0, (i == 0) ? 4'd1 : 4'd2, 1, 32'(i), 4'd0, 4'(i));
      tick();
    end
    idle();
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_dready got %0h exp 0", disp_ready); end
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_occ got %0d exp 16", occupancy); end
    drive(6'h07, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 4'd15);
    tick();
    idle();
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL full_drop_occ got %0d exp 16", occupancy); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL full_drop_issue got %0h exp 0", alu_valid); end
    cdb(0, 4'd1, 32'h55);
    tick();
    idle();
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_wake_dready got %0h exp 0", disp_ready); end
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd0) begin errors++; $display("FAIL full_issue got v %0h rob %0h exp v 1 rob 0", alu_valid, alu_rob); end
    checks++; if (alu_v1 !== 32'h55) begin errors++; $display("FAIL full_v1 got %0h exp 55", alu_v1); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL full_dready_after got %0h exp 1", disp_ready); end
    checks++; if (occupancy !== 5'd15) begin errors++; $display("FAIL full_occ_after got %0d exp 15", occupancy); end
  endtask

  task automatic test_flush();
    flush_in = 1'b1;
    tick();
    idle();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL flush_clear got %0d exp 0", occupancy); end
    for (int i = 0; i < 5; i++) begin
      drive(6'h08, 0, 32'd0, 4'd3, 1, 32'(i), 4'd0, 4'(i));
      tick();
    end
    checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL flush_occ5 got %0d exp 5", occupancy); end
    drive(6'h09, 1, 32'h1, 4'd0, 1, 32'h2, 4'd0, 4'd9);
    flush_in = 1'b1;
    tick();
    idle();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0h exp 0", alu_valid); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_disp_absent got %0h exp 0", alu_valid); end
    cdb(0, 4'd3, 32'h3);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b0 || occupancy !== 5'd0) begin errors++; $display("FAIL flush_ghost got v %0h occ %0d exp 0 0", alu_valid, occupancy); end
    alu_ready = 1'b0;
    drive(6'h0A, 1, 32'h1, 4'd0, 1, 32'h1, 4'd0, 4'd10);
    tick();
    idle();
    alu_ready = 1'b1;
    flush_in  = 1'b1;
    tick();
    idle();
    checks++; if (alu_valid !== 1'b0 || occupancy !== 5'd0) begin errors++; $display("FAIL flush_vs_issue got v %0h occ %0d exp 0 0", alu_valid, occupancy); end
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_issue_late got %0h exp 0", alu_valid); end
  endtask

  task automatic test_stall();
    drive(6'h0B, 1, 32'h33, 4'd0, 1, 32'h44, 4'd0, 4'd7);
    tick();
    idle();
    rdy_in = 1'b0;
    drive(6'h0C, 1, 32'h1, 4'd0, 1, 32'h1, 4'd0, 4'd8);
    flush_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (alu_valid !== 1'b0 || occupancy !== 5'd1) begin errors++; $display("FAIL stall_hold%0d got v %0h occ %0d exp 0 1", i, alu_valid, occupancy); end
    end
    idle();
    rdy_in = 1'b1;
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd7) begin errors++; $display("FAIL stall_issue got v %0h rob %0h exp 1 7", alu_valid, alu_rob); end
    checks++; if (alu_v1 !== 32'h33 || occupancy !== 5'd0) begin errors++; $display("FAIL stall_data got v1 %0h occ %0d exp 33 0", alu_v1, occupancy); end
    rdy_in = 1'b0;
    tick();
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL stall_freeze got %0h exp 1", alu_valid); end
    rdy_in = 1'b1;
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL stall_resume got %0h exp 0", alu_valid); end
  endtask

  task automatic test_reset_mid();
    drive(6'h0D, 0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 4'd1);
    tick();
    drive(6'h0D, 0, 32'd0, 4'd5, 1, 32'd0, 4'd0, 4'd2);
    tick();
    drive(6'h0E, 1, 32'h77, 4'd0, 1, 32'h88, 4'd0, 4'd3);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_v1 !== 32'h77 || occupancy !== 5'd2) begin errors++; $display("FAIL rmid_pre got v %0h v1 %0h occ %0d exp 1 77 2", alu_valid, alu_v1, occupancy); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (alu_valid !== 1'b0 || alu_v1 !== 32'h0 || alu_rob !== 4'h0) begin errors++; $display("FAIL rmid_alu got v %0h v1 %0h rob %0h exp 0 0 0", alu_valid, alu_v1, alu_rob); end
    checks++; if (occupancy !== 5'd0 || disp_ready !== 1'b1) begin errors++; $display("FAIL rmid_occ got occ %0d rdy %0h exp 0 1", occupancy, disp_ready); end
    #1 rst_in = 1'b1;
    drive(6'h0F, 1, 32'h5, 4'd0, 1, 32'h6, 4'd0, 4'd12);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b1 || alu_rob !== 4'd12) begin errors++; $display("FAIL rmid_post got v %0h rob %0h exp 1 c", alu_valid, alu_rob); end
    cdb(0, 4'd5, 32'h5);
    tick();
    idle();
    tick();
    checks++; if (alu_valid !== 1'b0 || occupancy !== 5'd0) begin errors++; $display("FAIL rmid_discard got v %0h occ %0d exp 0 0", alu_valid, occupancy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_cdb_priority();
    test_bypass();
    test_back_to_back();
    test_full();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
